// File: rtl/fft8_pkg.sv
// fft8_pkg: shared constants, types and helpers for the 8-point FFT pipe.
// Holds the stage growth offsets and the 1/sqrt(2) twiddle constant.
package fft8_pkg;

  localparam int STG1_GROW  = 1;
  localparam int STG2_GROW  = 2;
  localparam int STG3_GROW  = 4;
  localparam int CPLX_MAX_W = 32;

  typedef struct packed {
    logic signed [CPLX_MAX_W-1:0] re;
    logic signed [CPLX_MAX_W-1:0] im;
  } cplx_t;

  // round(0.70710678 * 2^(tw_w-1)) using a 2^30-scaled integer ratio
  function automatic int tw_const(input int tw_w);
    longint p;
    p = longint'(759250125) << (tw_w - 1);
    p = p + (longint'(1) << 29);
    return int'(p >>> 30);
  endfunction

endpackage

// File: rtl/fft8_bfly2.sv
// fft8_bfly2: complex add/subtract butterfly, one bit of growth.
// Inputs are sign-extended before the add so nothing wraps.
module fft8_bfly2
  import fft8_pkg::*;
#(
  parameter int W = 8
) (
  input  logic signed [W-1:0] a_re,
  input  logic signed [W-1:0] a_im,
  input  logic signed [W-1:0] b_re,
  input  logic signed [W-1:0] b_im,
  output logic signed [W:0]   s_re,
  output logic signed [W:0]   s_im,
  output logic signed [W:0]   d_re,
  output logic signed [W:0]   d_im
);

  // sum and difference at full width
  always_comb begin
    s_re = (W+1)'(a_re) + (W+1)'(b_re);
    s_im = (W+1)'(a_im) + (W+1)'(b_im);
    d_re = (W+1)'(a_re) - (W+1)'(b_re);
    d_im = (W+1)'(a_im) - (W+1)'(b_im);
  end

endmodule

// File: rtl/fft8_stream_pipe.sv
// fft8_stream_pipe: 3-stage 8-point radix-2 DIT FFT/IFFT, valid/ready.
// Define FFT8_ROUND_EN for round-half-up on the W8^1/W8^3 products.
module fft8_stream_pipe
  import fft8_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int TW_W   = 16,
  parameter int TAG_W  = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 s_valid,
  output logic                                 s_ready,
  input  logic [8*DATA_W-1:0]                  s_data_re,
  input  logic [8*DATA_W-1:0]                  s_data_im,
  input  logic                                 s_inv,
  input  logic [TAG_W-1:0]                     s_tag,
  output logic                                 m_valid,
  input  logic                                 m_ready,
  output logic [8*(DATA_W+STG3_GROW)-1:0]      m_data_re,
  output logic [8*(DATA_W+STG3_GROW)-1:0]      m_data_im,
  output logic                                 m_inv,
  output logic [TAG_W-1:0]                     m_tag
);

  localparam int OUT_W = DATA_W + STG3_GROW;
  localparam int W1    = DATA_W + STG1_GROW;
  localparam int W2    = DATA_W + STG2_GROW;
  localparam int WT    = W2 + 1;
  localparam int PW    = WT + TW_W;
  localparam logic signed [TW_W-1:0] C_TW = TW_W'(tw_const(TW_W));
`ifdef FFT8_ROUND_EN
  localparam logic signed [PW-1:0] RND = PW'(1) << (TW_W - 2);
`else
  localparam logic signed [PW-1:0] RND = '0;
`endif

  function automatic logic signed [WT-1:0] tw_mul(
    input logic signed [WT-1:0] t
  );
    logic signed [PW-1:0] p;
    p = PW'(t) * PW'(C_TW) + RND;
    p = p >>> (TW_W - 1);
    return p[WT-1:0];
  endfunction

  logic adv1, adv2, adv3;
  logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic inv1_q, inv1_d, inv2_q, inv2_d, inv3_q, inv3_d;
  logic [TAG_W-1:0] tag1_q, tag1_d, tag2_q, tag2_d, tag3_q, tag3_d;

  logic signed [DATA_W-1:0] x_re [8];
  logic signed [DATA_W-1:0] x_im [8];
  logic signed [W1-1:0] st1_re [8];
  logic signed [W1-1:0] st1_im [8];
  logic signed [W1-1:0] s1_re_q [8];
  logic signed [W1-1:0] s1_re_d [8];
  logic signed [W1-1:0] s1_im_q [8];
  logic signed [W1-1:0] s1_im_d [8];
  logic signed [W1-1:0] b2_re [4];
  logic signed [W1-1:0] b2_im [4];
  logic signed [W2-1:0] st2_re [8];
  logic signed [W2-1:0] st2_im [8];
  logic signed [W2-1:0] s2_re_q [8];
  logic signed [W2-1:0] s2_re_d [8];
  logic signed [W2-1:0] s2_im_q [8];
  logic signed [W2-1:0] s2_im_d [8];
  logic signed [WT-1:0] e_re [4];
  logic signed [WT-1:0] e_im [4];
  logic signed [WT-1:0] oa [4];
  logic signed [WT-1:0] ob [4];
  logic signed [WT-1:0] o_re [4];
  logic signed [WT-1:0] o_im [4];
  logic signed [OUT_W-1:0] st3_re [8];
  logic signed [OUT_W-1:0] st3_im [8];
  logic signed [OUT_W-1:0] s3_re_q [8];
  logic signed [OUT_W-1:0] s3_re_d [8];
  logic signed [OUT_W-1:0] s3_im_q [8];
  logic signed [OUT_W-1:0] s3_im_d [8];

  // stall-collapsing ready chain: an empty stage always accepts
  assign adv3 = !v3_q | m_ready;
  assign adv2 = !v2_q | adv3;
  assign adv1 = !v1_q | adv2;

  // unpack input samples
  always_comb begin
    for (int n = 0; n < 8; n++) begin
      x_re[n] = s_data_re[n*DATA_W +: DATA_W];
      x_im[n] = s_data_im[n*DATA_W +: DATA_W];
    end
  end

  // stage 1 pairs in bit-reversed order: (0,4) (2,6) (1,5) (3,7)
  for (genvar g = 0; g < 4; g++) begin : g_st1
    localparam int I0 = (g % 2) * 2 + g / 2;
    fft8_bfly2 #(.W(DATA_W)) u_bf (
      .a_re(x_re[I0]),     .a_im(x_im[I0]),
      .b_re(x_re[I0+4]),   .b_im(x_im[I0+4]),
      .s_re(st1_re[2*g]),  .s_im(st1_im[2*g]),
      .d_re(st1_re[2*g+1]), .d_im(st1_im[2*g+1])
    );
  end

  // stage 2 operands: odd term rotated by -j (fwd) or +j (inv)
  always_comb begin
    for (int h = 0; h < 2; h++) begin
      b2_re[2*h] = s1_re_q[4*h+2];
      b2_im[2*h] = s1_im_q[4*h+2];
      if (inv1_q) begin
        b2_re[2*h+1] = -s1_im_q[4*h+3];
        b2_im[2*h+1] = s1_re_q[4*h+3];
      end else begin
        b2_re[2*h+1] = s1_im_q[4*h+3];
        b2_im[2*h+1] = -s1_re_q[4*h+3];
      end
    end
  end

  // stage 2: slots 0..3 hold E0..E3, slots 4..7 hold O0..O3
  for (genvar g = 0; g < 4; g++) begin : g_st2
    localparam int IA = 4 * (g / 2) + (g % 2);
    fft8_bfly2 #(.W(W1)) u_bf (
      .a_re(s1_re_q[IA]),  .a_im(s1_im_q[IA]),
      .b_re(b2_re[g]),     .b_im(b2_im[g]),
      .s_re(st2_re[IA]),   .s_im(st2_im[IA]),
      .d_re(st2_re[IA+2]), .d_im(st2_im[IA+2])
    );
  end

  // stage 3 operands: E extended, O multiplied by W8^k
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      e_re[k] = WT'(s2_re_q[k]);
      e_im[k] = WT'(s2_im_q[k]);
      oa[k]   = WT'(s2_re_q[4+k]);
      ob[k]   = WT'(s2_im_q[4+k]);
    end
    o_re[0] = oa[0];
    o_im[0] = ob[0];
    if (inv2_q) begin
      o_re[1] = tw_mul(oa[1] - ob[1]);
      o_im[1] = tw_mul(oa[1] + ob[1]);
      o_re[2] = -ob[2];
      o_im[2] = oa[2];
      o_re[3] = tw_mul(-(oa[3] + ob[3]));
      o_im[3] = tw_mul(oa[3] - ob[3]);
    end else begin
      o_re[1] = tw_mul(oa[1] + ob[1]);
      o_im[1] = tw_mul(ob[1] - oa[1]);
      o_re[2] = ob[2];
      o_im[2] = -oa[2];
      o_re[3] = tw_mul(ob[3] - oa[3]);
      o_im[3] = tw_mul(-(oa[3] + ob[3]));
    end
  end

  // stage 3: X_k = E_k + W*O_k, X_k+4 = E_k - W*O_k
  for (genvar g = 0; g < 4; g++) begin : g_st3
    fft8_bfly2 #(.W(WT)) u_bf (
      .a_re(e_re[g]),     .a_im(e_im[g]),
      .b_re(o_re[g]),     .b_im(o_im[g]),
      .s_re(st3_re[g]),   .s_im(st3_im[g]),
      .d_re(st3_re[g+4]), .d_im(st3_im[g+4])
    );
  end

  // next state: each stage loads only when it advances
  always_comb begin
    v1_d = v1_q; inv1_d = inv1_q; tag1_d = tag1_q;
    v2_d = v2_q; inv2_d = inv2_q; tag2_d = tag2_q;
    v3_d = v3_q; inv3_d = inv3_q; tag3_d = tag3_q;
    s1_re_d = s1_re_q; s1_im_d = s1_im_q;
    s2_re_d = s2_re_q; s2_im_d = s2_im_q;
    s3_re_d = s3_re_q; s3_im_d = s3_im_q;
    if (adv1) begin
      v1_d = s_valid; inv1_d = s_inv; tag1_d = s_tag;
      s1_re_d = st1_re; s1_im_d = st1_im;
    end
    if (adv2) begin
      v2_d = v1_q; inv2_d = inv1_q; tag2_d = tag1_q;
      s2_re_d = st2_re; s2_im_d = st2_im;
    end
    if (adv3) begin
      v3_d = v2_q; inv3_d = inv2_q; tag3_d = tag2_q;
      s3_re_d = st3_re; s3_im_d = st3_im;
    end
  end

  // pipeline registers, synchronous reset clears everything
  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q <= 1'b0; inv1_q <= 1'b0; tag1_q <= '0;
      v2_q <= 1'b0; inv2_q <= 1'b0; tag2_q <= '0;
      v3_q <= 1'b0; inv3_q <= 1'b0; tag3_q <= '0;
      s1_re_q <= '{default: '0}; s1_im_q <= '{default: '0};
      s2_re_q <= '{default: '0}; s2_im_q <= '{default: '0};
      s3_re_q <= '{default: '0}; s3_im_q <= '{default: '0};
    end else begin
      v1_q <= v1_d; inv1_q <= inv1_d; tag1_q <= tag1_d;
      v2_q <= v2_d; inv2_q <= inv2_d; tag2_q <= tag2_d;
      v3_q <= v3_d; inv3_q <= inv3_d; tag3_q <= tag3_d;
      s1_re_q <= s1_re_d; s1_im_q <= s1_im_d;
      s2_re_q <= s2_re_d; s2_im_q <= s2_im_d;
      s3_re_q <= s3_re_d; s3_im_q <= s3_im_d;
    end
  end

  // outputs come straight from stage 3
  always_comb begin
    s_ready = adv1;
    m_valid = v3_q;
    m_inv   = inv3_q;
    m_tag   = tag3_q;
    for (int k = 0; k < 8; k++) begin
      m_data_re[k*OUT_W +: OUT_W] = s3_re_q[k];
      m_data_im[k*OUT_W +: OUT_W] = s3_im_q[k];
    end
  end

endmodule

// File: tb/tb_fft8_stream_pipe.sv
// tb_fft8_stream_pipe: directed vectors with a queue-based scoreboard.
// Build with FFT8_ROUND_EN defined to check the rounding variant.
module tb_fft8_stream_pipe;

  localparam int DATA_W = 8;
  localparam int TW_W   = 16;
  localparam int TAG_W  = 4;
  localparam int OUT_W  = DATA_W + 4;
  localparam int VW     = 8 * OUT_W;

  logic                 clk;
  logic                 reset;
  logic                 s_valid;
  logic                 s_ready;
  logic [8*DATA_W-1:0]  s_data_re;
  logic [8*DATA_W-1:0]  s_data_im;
  logic                 s_inv;
  logic [TAG_W-1:0]     s_tag;
  logic                 m_valid;
  logic                 m_ready;
  logic [VW-1:0]        m_data_re;
  logic [VW-1:0]        m_data_im;
  logic                 m_inv;
  logic [TAG_W-1:0]     m_tag;

  fft8_stream_pipe #(
    .DATA_W(DATA_W), .TW_W(TW_W), .TAG_W(TAG_W)
  ) dut (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_data_re(s_data_re), .s_data_im(s_data_im),
    .s_inv(s_inv), .s_tag(s_tag),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_data_re(m_data_re), .m_data_im(m_data_im),
    .m_inv(m_inv), .m_tag(m_tag)
  );

  typedef struct packed {
    logic [VW-1:0]    re;
    logic [VW-1:0]    im;
    logic             inv;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;
  int xr[8], xi[8], er[8], ei[8];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chkv(input string nm, input logic [VW-1:0] got,
                      input logic [VW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic chki(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  task automatic zero_all();
    for (int k = 0; k < 8; k++) begin
      xr[k] = 0; xi[k] = 0; er[k] = 0; ei[k] = 0;
    end
  endtask

  task automatic exp_all(input int r, input int i);
    for (int k = 0; k < 8; k++) begin
      er[k] = r; ei[k] = i;
    end
  endtask

  // drive one transaction, push its expectation on handshake
  task automatic send(input bit inv, input int tag);
    exp_t e;
    bit rdy;
    int n;
    for (int k = 0; k < 8; k++) begin
      s_data_re[k*DATA_W +: DATA_W] = xr[k][DATA_W-1:0];
      s_data_im[k*DATA_W +: DATA_W] = xi[k][DATA_W-1:0];
      e.re[k*OUT_W +: OUT_W] = er[k][OUT_W-1:0];
      e.im[k*OUT_W +: OUT_W] = ei[k][OUT_W-1:0];
    end
    e.inv = inv;
    e.tag = tag[TAG_W-1:0];
    s_inv = inv;
    s_tag = tag[TAG_W-1:0];
    s_valid = 1'b1;
    rdy = 1'b0;
    n = 0;
    while (!rdy && n < 50) begin
      @(negedge clk);
      rdy = s_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (rdy) sb.push_back(e);
    else begin
      checks++;
      errors++;
      $display("FAIL send_timeout tag=%0d got=no_accept exp=accept", tag);
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chki("drain_empty", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // monitor: pop and compare on every output handshake
  always @(negedge clk) begin
    if (!reset && m_valid && m_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output got=tag%0d exp=none", m_tag);
      end else begin
        mon_e = sb.pop_front();
        chkv("out_re", m_data_re, mon_e.re);
        chkv("out_im", m_data_im, mon_e.im);
        chki("out_inv", int'(m_inv), int'(mon_e.inv));
        chki("out_tag", int'(m_tag), int'(mon_e.tag));
      end
    end
  end

  // backpressure watcher: fill level at stall, hold while stalled
  bit bp_on = 1'b0;
  bit stall_seen = 1'b0;
  bit prev_stall = 1'b0;
  int acc = 0;
  int del = 0;
  logic [VW-1:0] prev_re, prev_im;
  logic [TAG_W-1:0] prev_tag;

  always @(negedge clk) begin
    if (bp_on) begin
      if (!s_ready) begin
        stall_seen = 1'b1;
        chki("bp_inflight", acc - del, 3);
      end
      if (prev_stall) begin
        chki("bp_hold_valid", int'(m_valid), 1);
        chkv("bp_hold_re", m_data_re, prev_re);
        chkv("bp_hold_im", m_data_im, prev_im);
        chki("bp_hold_tag", int'(m_tag), int'(prev_tag));
      end
      prev_stall = m_valid && !m_ready;
      prev_re  = m_data_re;
      prev_im  = m_data_im;
      prev_tag = m_tag;
      if (s_valid && s_ready) acc++;
      if (m_valid && m_ready) del++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; s_valid = 1'b0; s_inv = 1'b0; s_tag = '0;
    s_data_re = '0; s_data_im = '0; m_ready = 1'b1;
    zero_all();
    repeat (3) @(posedge clk);
    #1;
    chki("rst_m_valid", int'(m_valid), 0);
    chkv("rst_m_re", m_data_re, '0);
    chkv("rst_m_im", m_data_im, '0);
    chki("rst_m_tag", int'(m_tag), 0);
    chki("rst_m_inv", int'(m_inv), 0);
    reset = 1'b0;
    @(negedge clk);
    chki("rst_s_ready", int'(s_ready), 1);
    @(posedge clk);
    #1;

    // impulse with latency check
    zero_all(); xr[0] = 1; exp_all(1, 0);
    send(1'b0, 1);
    s_valid = 1'b0;
    @(negedge clk); chki("lat_c1", int'(m_valid), 0);
    @(negedge clk); chki("lat_c2", int'(m_valid), 0);
    @(negedge clk); chki("lat_c3", int'(m_valid), 1);
    @(posedge clk);
    #1;

    // DC forward and inverse
    zero_all();
    for (int k = 0; k < 8; k++) xr[k] = 5;
    er[0] = 40;
    send(1'b0, 2);
    send(1'b1, 3);

    // single tone on x1, forward
    zero_all(); xr[1] = 100;
`ifdef FFT8_ROUND_EN
    er = '{100, 71, 0, -71, -100, -71, 0, 71};
`else
    er = '{100, 70, 0, -71, -100, -70, 0, 71};
`endif
    ei = '{0, -71, -100, -71, 0, 71, 100, 71};
    send(1'b0, 4);

    // same tone, inverse
`ifdef FFT8_ROUND_EN
    er = '{100, 71, 0, -71, -100, -71, 0, 71};
    ei = '{0, 71, 100, 71, 0, -71, -100, -71};
`else
    er = '{100, 70, 0, -71, -100, -70, 0, 71};
    ei = '{0, 70, 100, 70, 0, -70, -100, -70};
`endif
    send(1'b1, 10);

    // x2 = 1 exercises the stage 2 rotation
    zero_all(); xr[2] = 1;
    er = '{1, 0, -1, 0, 1, 0, -1, 0};
    ei = '{0, -1, 0, 1, 0, -1, 0, 1};
    send(1'b0, 5);

    // complex impulse, inverse
    zero_all(); xr[0] = 3; xi[0] = 4; exp_all(3, 4);
    send(1'b1, 6);

    // full-scale negative DC
    zero_all();
    for (int k = 0; k < 8; k++) begin
      xr[k] = -128; xi[k] = -128;
    end
    er[0] = -1024; ei[0] = -1024;
    send(1'b0, 7);
    s_valid = 1'b0;
    drain(30);

    // backpressure: m_ready low for cycles 4..9
    bp_on = 1'b1;
    fork
      begin
        for (int t = 1; t <= 6; t++) begin
          zero_all(); xr[0] = t; exp_all(t, 0);
          send(1'b0, t);
        end
        s_valid = 1'b0;
      end
      begin
        repeat (4) @(posedge clk);
        #1 m_ready = 1'b0;
        repeat (6) @(posedge clk);
        #1 m_ready = 1'b1;
      end
    join
    drain(40);
    bp_on = 1'b0;
    chki("bp_stall_seen", int'(stall_seen), 1);
    chki("bp_delivered", del, 6);

    // reset with three transactions in flight
    m_ready = 1'b0;
    for (int t = 7; t <= 9; t++) begin
      zero_all(); xr[0] = t; exp_all(t, 0);
      send(1'b1, t);
    end
    s_valid = 1'b0;
    chki("pre_rst_valid", int'(m_valid), 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chki("mid_rst_valid", int'(m_valid), 0);
    chkv("mid_rst_re", m_data_re, '0);
    chkv("mid_rst_im", m_data_im, '0);
    chki("mid_rst_tag", int'(m_tag), 0);
    chki("mid_rst_inv", int'(m_inv), 0);
    sb.delete();
    reset = 1'b0;
    m_ready = 1'b1;
    @(negedge clk);
    chki("post_rst_s_ready", int'(s_ready), 1);
    repeat (8) begin
      @(negedge clk);
      chki("post_rst_idle", int'(m_valid), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft8_stream_pipe.md
Name: fft8_stream_pipe

Overview:
- Parametrised successor of the team's fixed 8-bit, real-input 8-point FFT. Computes an 8-point radix-2 DIT DFT on complex inputs of width DATA_W in a 3-stage pipeline.
- Full valid/ready backpressure with a stall-collapsing ready chain, so partially filled pipelines keep draining.
- Per-transaction forward/inverse mode and a user tag carried alongside the data.
- Sits between a sample framer upstream and the spectral post-processing downstream.

Parameters:
- DATA_W, 8: signed width of each input real/imag component.
- TW_W, 16: signed twiddle width. Constant C = round(0.70710678 * 2^(TW_W-1)), which is 23170 for TW_W=16.
- TAG_W, 4: width of the user tag passed through with each transaction.
- OUT_W: localparam = DATA_W+4, the signed width of each output component. Not overridable.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- s_valid  in  1  input transaction valid.
- s_ready  out  1  input accept.
- s_data_re  in  8*DATA_W  x0..x7 real parts; x_n occupies bits [n*DATA_W +: DATA_W], signed.
- s_data_im  in  8*DATA_W  x0..x7 imaginary parts, same packing.
- s_inv  in  1  1 = inverse DFT (conjugate twiddles), 0 = forward.
- s_tag  in  TAG_W  user tag.
- m_valid  out  1  output valid.
- m_ready  in  1  downstream accept.
- m_data_re  out  8*OUT_W  X0..X7 real parts in natural order; X_k at [k*OUT_W +: OUT_W].
- m_data_im  out  8*OUT_W  X0..X7 imaginary parts, same packing.
- m_inv  out  1  s_inv of this transaction.
- m_tag  out  TAG_W  s_tag of this transaction.

Behaviour:
- Pipeline registers S1, S2, S3 with valid bits v1, v2, v3; m_valid = v3.
- Advance chain:
  - adv3 = !v3 | m_ready
  - adv2 = !v2 | adv3
  - adv1 = !v1 | adv2
  - s_ready = adv1
- Stage k loads, including its valid, inv and tag, only when adv_k. v1 <= s_valid when adv1, and similarly down the chain.
- Data registers hold when not advancing.
- Latency: 3 cycles from input handshake to m_valid, with no stall.
- Throughput: 1 transaction per cycle.
- Bubbles collapse: an empty stage accepts new data even while m_ready=0.
- While m_valid=1 and m_ready=0, all m_* outputs are held stable.
- Stage 1: 2-point butterflies on pairs (x0,x4), (x2,x6), (x1,x5), (x3,x7). Sum and difference are sign-extended to DATA_W+1. No truncation.
- Stage 2: 4-point combine with twiddle -j (forward) or +j (inverse). Implemented as a re/im swap and negate. Width DATA_W+2.
- Stage 3: combine with W8^k, k=0..3, using X_k = E_k + W·O_k and X_{k+4} = E_k - W·O_k.
  - W8^0 = 1.
  - W8^2 = -j (forward) or +j (inverse), done as swap/negate.
  - W8^1 and W8^3: component products are computed as (a±b)*C, then arithmetic right shift by TW_W-1 (floor).
  - Sign pattern for W8^1 and W8^3 is conjugated in inverse mode.
  - Result is sign-extended to OUT_W.
- No 1/8 scaling in inverse mode. No saturation: OUT_W covers worst-case growth.
- Reset:
  - v1..v3 = 0, so m_valid = 0.
  - m_data_re, m_data_im, m_tag and m_inv = 0; all stage data registers = 0.
  - s_ready = 1 in the cycle after reset deasserts.
  - Reset asserted mid-stream discards every in-flight transaction. No partial output appears.
- Simultaneous m_ready=1 and s_valid=1 with a full pipeline: all stages shift and one transaction is accepted and one delivered in the same cycle.

Optional Feature:
- FFT8_ROUND_EN defined: each twiddle product adds 2^(TW_W-2) before the shift (round-half-up).
- Undefined: plain floor truncation.
- Affects stage 3 W8^1 and W8^3 products only.

Decomposition:
- Package fft8_pkg holds:
  - function computing twiddle constant C from TW_W;
  - localparam stage width offsets (+1, +2, +4);
  - complex struct typedef parametrised by width.
- One sub-module, fft8_bfly2: a width-parametrised complex add/subtract butterfly, instantiated in all three stages.
- The twiddle multiply stays in the top level.

Test Plan:
- Impulse: x0 = 1+0j, others 0, forward → all X_k = 1+0j; m_valid exactly 3 cycles after the handshake.
- DC: all x_n = 5+0j → X0 = 40+0j, X1..X7 = 0; the same with s_inv=1 gives an identical result.
- x1 = 100, others 0, forward, TW_W=16:
  - without FFT8_ROUND_EN → X1 = 70-71j;
  - with FFT8_ROUND_EN → X1 = 71-71j;
  - in both cases X2 = 0-100j and X4 = -100+0j.
- The same stimulus with s_inv=1:
  - without FFT8_ROUND_EN → X1 = 70+70j;
  - with FFT8_ROUND_EN → X1 = 71+71j;
  - X2 = 0+100j;
  - m_inv = 1 and m_tag echoes s_tag.
- Backpressure:
  - 6 back-to-back transactions with tags 1..6 while m_ready is low for cycles 4-9 → s_ready drops only once 3 transactions are held;
  - outputs stay stable while stalled;
  - tags emerge in order 1..6 with no loss or duplication.
- Reset mid-stream:
  - assert reset with 3 transactions in flight → m_valid = 0 and all outputs 0 on the next cycle;
  - no stale tag appears afterwards.
